// File: rtl/axi_tb_pkg.sv
// Shared types and constants for the AXI master write driver.
package axi_tb_pkg;

    // Widest address/ID a command can carry; narrower buses zero-extend into these.
    localparam int CMD_ADDR_W = 64;
    localparam int CMD_ID_W   = 16;

    // Fibonacci taps 16,14,13,11 for a right-shifting register (bits 0,2,3,5 feed bit 15).
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_e;

    typedef struct packed {
        logic [CMD_ADDR_W-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [CMD_ID_W-1:0]   id;
    } aw_cmd_t;

endpackage

// File: rtl/axi_mst_wr_driver_if.sv
// Observed AW channel plus driven W channel and B channel of the write driver.
interface axi_mst_wr_driver_if #(
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_ID_W   = 4,
    parameter int AXI_DATA_W = 32
) ();
    logic                    in_awvalid;
    logic                    in_awready;
    logic [AXI_ADDR_W-1:0]   in_awaddr;
    logic [7:0]              in_awlen;
    logic [2:0]              in_awsize;
    logic [AXI_ID_W-1:0]     in_awid;

    logic                    out_wvalid;
    logic                    in_wready;
    logic                    out_wlast;
    logic [AXI_ID_W-1:0]     out_wid;
    logic [AXI_DATA_W-1:0]   out_wdata;
    logic [AXI_DATA_W/8-1:0] out_wstrb;

    logic                    in_bvalid;
    logic                    out_bready;
    logic [AXI_ID_W-1:0]     in_bid;
    logic [1:0]              in_bresp;

    modport master (
        input  in_awvalid, in_awready, in_awaddr, in_awlen, in_awsize, in_awid,
        input  in_wready, in_bvalid, in_bid, in_bresp,
        output out_wvalid, out_wlast, out_wid, out_wdata, out_wstrb, out_bready
    );

    modport slave (
        output in_awvalid, in_awready, in_awaddr, in_awlen, in_awsize, in_awid,
        output in_wready, in_bvalid, in_bid, in_bresp,
        input  out_wvalid, out_wlast, out_wid, out_wdata, out_wstrb, out_bready
    );
endinterface

// File: rtl/axi_tb_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; DEPTH must be a power of 2 and at least 2.
module axi_tb_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             srst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push, do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) && (wr_ptr[IDX_W] != rd_ptr[IDX_W]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[IDX_W-1:0]];

    // Push and pop are independent, so a simultaneous pair leaves occupancy unchanged.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (srst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge aclk) begin
        if (do_push) mem[wr_ptr[IDX_W-1:0]] <= din;
    end

endmodule

// File: rtl/axi_mst_wr_driver.sv
// AXI write-data driver: queues observed AW commands and emits matching W bursts, tracks B.
// Define AXI_MST_WR_BCHK_EN to add the saturating err_cnt output and protocol $error checks.
module axi_mst_wr_driver
    import axi_tb_pkg::*;
#(
    parameter int          AXI_ADDR_W      = 32,
    parameter int          AXI_ID_W        = 4,
    parameter int          AXI_DATA_W      = 32,
    parameter int          MST_OSTDREQ_NUM = 4,
    parameter int          BREADY_MODE     = 1,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic                               aclk,
    input  logic                               aresetn,
    input  logic                               srst,
    axi_mst_wr_driver_if.master                bus,
    output logic                               cmd_full,
    output logic [$clog2(MST_OSTDREQ_NUM):0]   ostd_cnt
`ifdef AXI_MST_WR_BCHK_EN
    ,
    output logic [15:0]                        err_cnt
`endif
);
    localparam int STRB_W = AXI_DATA_W / 8;
    localparam int LANE_W = $clog2(STRB_W);
    localparam int OSTD_W = $clog2(MST_OSTDREQ_NUM) + 1;

    function automatic logic [STRB_W-1:0] calc_strb(input logic [LANE_W-1:0] addr_lo,
                                                    input logic [7:0]        beat,
                                                    input logic [2:0]        size);
        logic [LANE_W-1:0] lane;
        logic [LANE_W-1:0] align;
        logic [STRB_W-1:0] ones;
        if (int'(size) >= LANE_W) return '1;
        lane  = addr_lo + LANE_W'(beat << size);
        align = LANE_W'((1 << size) - 1);
        lane  = lane & ~align;
        ones  = STRB_W'((1 << (1 << size)) - 1);
        return ones << lane;
    endfunction

    function automatic logic [AXI_DATA_W-1:0] byte_mask(input logic [STRB_W-1:0] strb);
        logic [AXI_DATA_W-1:0] m;
        for (int i = 0; i < STRB_W; i++) m[i*8 +: 8] = {8{strb[i]}};
        return m;
    endfunction

    aw_cmd_t               push_cmd, head;
    logic                  empty, aw_hs, w_hs, wlast_hs, b_hs;
    logic [7:0]            beat_cnt;
    logic [AXI_DATA_W-1:0] wdata_q;
    logic [15:0]           lfsr;
    logic                  bready_q;

    always_comb begin
        push_cmd      = '0;
        push_cmd.addr = CMD_ADDR_W'(bus.in_awaddr);
        push_cmd.len  = bus.in_awlen;
        push_cmd.size = bus.in_awsize;
        push_cmd.id   = CMD_ID_W'(bus.in_awid);
    end

    assign aw_hs = bus.in_awvalid && bus.in_awready;

    axi_tb_sync_fifo #(
        .WIDTH ($bits(aw_cmd_t)),
        .DEPTH (MST_OSTDREQ_NUM)
    ) u_cmd_fifo (
        .aclk    (aclk),
        .aresetn (aresetn),
        .srst    (srst),
        .push    (aw_hs),
        .pop     (wlast_hs),
        .din     (push_cmd),
        .dout    (head),
        .full    (cmd_full),
        .empty   (empty)
    );

    assign bus.out_wvalid = !empty;
    assign bus.out_wlast  = (beat_cnt == head.len) && bus.out_wvalid;
    assign bus.out_wid    = head.id[AXI_ID_W-1:0];
    assign bus.out_wstrb  = bus.out_wvalid ? calc_strb(head.addr[LANE_W-1:0], beat_cnt, head.size) : '0;
    assign bus.out_wdata  = wdata_q;
    assign bus.out_bready = bready_q;

    assign w_hs     = bus.out_wvalid && bus.in_wready;
    assign wlast_hs = w_hs && bus.out_wlast;
    assign b_hs     = bus.in_bvalid && bus.out_bready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            beat_cnt <= '0;
            wdata_q  <= '0;
        end else if (srst) begin
            beat_cnt <= '0;
            wdata_q  <= '0;
        end else if (w_hs) begin
            beat_cnt <= wlast_hs ? 8'd0 : beat_cnt + 8'd1;
            wdata_q  <= (wdata_q + AXI_DATA_W'(1)) & byte_mask(bus.out_wstrb);
        end
    end

    // A burst closing in the same cycle as a B response nets to no change.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ostd_cnt <= '0;
        end else if (srst) begin
            ostd_cnt <= '0;
        end else if (wlast_hs && !b_hs) begin
            ostd_cnt <= ostd_cnt + OSTD_W'(1);
        end else if (b_hs && !wlast_hs && (ostd_cnt != '0)) begin
            ostd_cnt <= ostd_cnt - OSTD_W'(1);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            lfsr     <= LFSR_SEED;
            bready_q <= (BREADY_MODE == 0);
        end else if (srst) begin
            lfsr     <= LFSR_SEED;
            bready_q <= (BREADY_MODE == 0);
        end else begin
            lfsr     <= {^(lfsr & LFSR_TAPS), lfsr[15:1]};
            bready_q <= (BREADY_MODE == 0) ? 1'b1 : lfsr[0];
        end
    end

`ifdef AXI_MST_WR_BCHK_EN
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] inc);
        logic [16:0] s;
        s = {1'b0, a} + 17'(inc);
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    logic b_orphan, b_bad_resp, aw_drop;

    assign b_orphan   = b_hs && (ostd_cnt == '0);
    assign b_bad_resp = b_hs && (resp_e'(bus.in_bresp) != OKAY);
    assign aw_drop    = aw_hs && cmd_full;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err_cnt <= '0;
        end else if (srst) begin
            err_cnt <= '0;
        end else begin
            err_cnt <= sat_add16(err_cnt, 2'(b_orphan) + 2'(b_bad_resp) + 2'(aw_drop));
        end
    end

    always_ff @(posedge aclk) begin
        if (aresetn && !srst) begin
            if (b_orphan)   $error("B handshake with no outstanding burst");
            if (b_bad_resp) $error("B response not OKAY: %0d", bus.in_bresp);
            if (aw_drop)    $error("AW handshake dropped, command FIFO full");
        end
    end
`endif

    logic unused_bits;
    assign unused_bits = ^{head.addr, head.id, bus.in_bid};

endmodule
